// File: rtl/march_controller.sv
// March C- sequencer for the PMBIST datapath: drives a single-port synchronous
// memory, presents expected read data to the comparator and accumulates status.
module march_controller #(
    parameter int dw = 8,
    parameter int aw = 4,
    parameter int cw = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [aw-1:0] mem_addr,
    output logic          mem_we,
    output logic          mem_re,
    output logic [dw-1:0] mem_wdata,
    output logic [dw-1:0] exp_data,
    input  logic          cmp_fail,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [aw-1:0] fail_addr,
    output logic [2:0]    fail_elem,
    output logic [cw-1:0] err_count
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [aw-1:0] addr_zero = {aw{1'b0}};
    localparam logic [aw-1:0] addr_max  = {aw{1'b1}};
    localparam logic [aw-1:0] addr_one  = {{(aw-1){1'b0}}, 1'b1};
    localparam logic [cw-1:0] cnt_max   = {cw{1'b1}};
    localparam logic [cw-1:0] cnt_one   = {{(cw-1){1'b0}}, 1'b1};

    state_t        state_r;
    logic [2:0]    elem_r;
    logic          op_r;
    logic [aw-1:0] addr_r;
    logic          chk_valid_r;
    logic [aw-1:0] chk_addr_r;
    logic [2:0]    chk_elem_r;

    logic [2:0]    n_elem_s;
    logic          n_op_s;
    logic [aw-1:0] n_addr_s;
    logic          run_end_s;

    function automatic logic is_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic two_ops(input logic [2:0] e);
        return (e != 3'd0) && (e != 3'd5);
    endfunction

    // Op 0 of the two-op elements is the read, op 1 the write.
    function automatic logic is_write(input logic [2:0] e, input logic op);
        case (e)
            3'd0:    return 1'b1;
            3'd5:    return 1'b0;
            default: return op;
        endcase
    endfunction

    function automatic logic [dw-1:0] wr_bg(input logic [2:0] e);
        return ((e == 3'd1) || (e == 3'd3)) ? {dw{1'b1}} : {dw{1'b0}};
    endfunction

    function automatic logic [dw-1:0] rd_bg(input logic [2:0] e);
        return ((e == 3'd2) || (e == 3'd4)) ? {dw{1'b1}} : {dw{1'b0}};
    endfunction

    // Next element/op/address after the operation currently on the bus.
    always_comb begin
        n_elem_s  = elem_r;
        n_op_s    = 1'b0;
        n_addr_s  = addr_r;
        run_end_s = 1'b0;
        if (two_ops(elem_r) && !op_r) begin
            n_op_s = 1'b1;
        end else if (is_down(elem_r) ? (addr_r != addr_zero) : (addr_r != addr_max)) begin
            n_addr_s = is_down(elem_r) ? (addr_r - addr_one) : (addr_r + addr_one);
        end else if (elem_r == 3'd5) begin
            run_end_s = 1'b1;
        end else begin
            n_elem_s = elem_r + 3'd1;
            n_addr_s = is_down(elem_r + 3'd1) ? addr_max : addr_zero;
        end
    end

    // Run FSM, registered memory strobes and status accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            elem_r    <= 3'd0;
            op_r      <= 1'b0;
            addr_r    <= addr_zero;
            mem_addr  <= addr_zero;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_wdata <= {dw{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= addr_zero;
            fail_elem <= 3'd0;
            err_count <= {cw{1'b0}};
        end else begin
            if (chk_valid_r && cmp_fail) begin
                if (err_count != cnt_max) begin
                    err_count <= err_count + cnt_one;
                end
                if (!fail) begin
                    fail      <= 1'b1;
                    fail_addr <= chk_addr_r;
                    fail_elem <= chk_elem_r;
                end
            end
            // A start can only land here while no check is pending, so the clear wins cleanly.
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r   <= RUN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        fail      <= 1'b0;
                        fail_addr <= addr_zero;
                        fail_elem <= 3'd0;
                        err_count <= {cw{1'b0}};
                        elem_r    <= 3'd0;
                        op_r      <= 1'b0;
                        addr_r    <= addr_zero;
                        mem_addr  <= addr_zero;
                        mem_we    <= 1'b1;
                        mem_re    <= 1'b0;
                        mem_wdata <= wr_bg(3'd0);
                    end
                end
                RUN: begin
                    if (run_end_s) begin
                        state_r <= FLUSH;
                        mem_we  <= 1'b0;
                        mem_re  <= 1'b0;
                    end else begin
                        elem_r    <= n_elem_s;
                        op_r      <= n_op_s;
                        addr_r    <= n_addr_s;
                        mem_addr  <= n_addr_s;
                        mem_we    <= is_write(n_elem_s, n_op_s);
                        mem_re    <= !is_write(n_elem_s, n_op_s);
                        mem_wdata <= wr_bg(n_elem_s);
                    end
                end
                FLUSH: begin
                    state_r <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Read check pipeline: expected data lines up with the memory's read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_valid_r <= 1'b0;
            chk_addr_r  <= addr_zero;
            chk_elem_r  <= 3'd0;
            exp_data    <= {dw{1'b0}};
        end else begin
            chk_valid_r <= mem_re;
            if (mem_re) begin
                chk_addr_r <= mem_addr;
                chk_elem_r <= elem_r;
                exp_data   <= rd_bg(elem_r);
            end
        end
    end

endmodule

// File: tb/tb_march_controller.sv
// Self-checking bench for march_controller: scoreboarded op trace, table of runs,
// plus hand-written mid-run reset sequence.
module tb_march_controller;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    int         fault_mode;

    logic [3:0] mem_addr,  mem_addr4;
    logic       mem_we,    mem_we4;
    logic       mem_re,    mem_re4;
    logic [7:0] mem_wdata, mem_wdata4;
    logic [7:0] exp_data,  exp_data4;
    logic       cmp_fail,  cmp_fail4;
    logic       busy,      busy4;
    logic       done,      done4;
    logic       fail,      fail4;
    logic [3:0] fail_addr, fail_addr4;
    logic [2:0] fail_elem, fail_elem4;
    logic [7:0] err_count;
    logic [3:0] err_count4;

    int checks = 0;
    int errors = 0;

    march_controller #(.dw(8), .aw(4), .cw(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
        .exp_data(exp_data), .cmp_fail(cmp_fail), .busy(busy), .done(done),
        .fail(fail), .fail_addr(fail_addr), .fail_elem(fail_elem), .err_count(err_count)
    );

    march_controller #(.dw(8), .aw(4), .cw(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_addr(mem_addr4), .mem_we(mem_we4), .mem_re(mem_re4), .mem_wdata(mem_wdata4),
        .exp_data(exp_data4), .cmp_fail(cmp_fail4), .busy(busy4), .done(done4),
        .fail(fail4), .fail_addr(fail_addr4), .fail_elem(fail_elem4), .err_count(err_count4)
    );

    always #5 clk = ~clk;

    // Memory A: optional stuck-at-1 on bit 0 of address 5. Memory B: always inverted.
    logic [7:0] mem_a [N];
    logic [7:0] mem_b [N];
    logic [7:0] rdata_a = 8'h00;
    logic [7:0] rdata_b = 8'h00;

    always @(posedge clk) begin
        if (mem_we) mem_a[mem_addr] <= mem_wdata;
        if (mem_re) rdata_a <= mem_a[mem_addr] | ((fault_mode == 1 && mem_addr == 4'd5) ? 8'h01 : 8'h00);
        if (mem_we4) mem_b[mem_addr4] <= mem_wdata4;
        if (mem_re4) rdata_b <= ~mem_b[mem_addr4];
    end

    assign cmp_fail  = (rdata_a != exp_data);
    assign cmp_fail4 = (rdata_b != exp_data4);

    typedef struct {
        bit         we;
        bit         re;
        logic [3:0] addr;
        logic [7:0] wd;
        logic [7:0] rexp;
    } op_t;

    typedef struct {
        string      name;
        int         fault;
        bit         repulse;
        bit         efail;
        logic [3:0] eaddr;
        logic [2:0] eelem;
        logic [7:0] eerr;
    } vec_t;

    op_t        trace_q[$];
    logic [7:0] exp_q[$];
    vec_t       vecs[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_op(input bit we, input logic [3:0] a, input logic [7:0] d);
        op_t o;
        o.we   = we;
        o.re   = !we;
        o.addr = a;
        o.wd   = we ? d : 8'h00;
        o.rexp = we ? 8'h00 : d;
        trace_q.push_back(o);
    endtask

    // Reference March C- trace written out element by element.
    task automatic build_trace();
        logic [3:0] a;
        trace_q.delete();
        exp_q.delete();
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                a = (e == 3 || e == 4) ? 4'(N - 1 - i) : 4'(i);
                case (e)
                    0: push_op(1'b1, a, 8'h00);
                    1: begin push_op(1'b0, a, 8'h00); push_op(1'b1, a, 8'hFF); end
                    2: begin push_op(1'b0, a, 8'hFF); push_op(1'b1, a, 8'h00); end
                    3: begin push_op(1'b0, a, 8'h00); push_op(1'b1, a, 8'hFF); end
                    4: begin push_op(1'b0, a, 8'hFF); push_op(1'b1, a, 8'h00); end
                    default: push_op(1'b0, a, 8'h00);
                endcase
            end
        end
    endtask

    task automatic check_exp_pending();
        logic [7:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("exp_data", 32'(exp_data), 32'(e));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_we"},    32'(mem_we),    32'd0);
        chk({tag, "_re"},    32'(mem_re),    32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_exp"},   32'(exp_data),  32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_done"},  32'(done),      32'd0);
        chk({tag, "_fail"},  32'(fail),      32'd0);
        chk({tag, "_faddr"}, 32'(fail_addr), 32'd0);
        chk({tag, "_felem"}, 32'(fail_elem), 32'd0);
        chk({tag, "_err"},   32'(err_count), 32'd0);
        chk({tag, "_fail4"}, 32'(fail4),     32'd0);
        chk({tag, "_err4"},  32'(err_count4), 32'd0);
    endtask

    // One full run: start pulse, 10N traced RUN cycles, FLUSH, DONE and status.
    task automatic do_run(input vec_t v);
        op_t o;
        fault_mode = v.fault;
        build_trace();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 10 * N; k++) begin
            if (k > 0) @(negedge clk);
            start = v.repulse && (k == 40);
            check_exp_pending();
            o = trace_q.pop_front();
            chk("mem_we",   32'(mem_we),   32'(o.we));
            chk("mem_re",   32'(mem_re),   32'(o.re));
            chk("mem_addr", 32'(mem_addr), 32'(o.addr));
            if (o.we) chk("mem_wdata", 32'(mem_wdata), 32'(o.wd));
            if (o.re) exp_q.push_back(o.rexp);
            if (k == 0 || k == 10 * N - 1) chk("busy_run", 32'(busy), 32'd1);
        end
        @(negedge clk);
        check_exp_pending();
        chk("flush_busy", 32'(busy),   32'd1);
        chk("flush_done", 32'(done),   32'd0);
        chk("flush_we",   32'(mem_we), 32'd0);
        chk("flush_re",   32'(mem_re), 32'd0);
        @(negedge clk);
        chk({v.name, "_done"},  32'(done),      32'd1);
        chk({v.name, "_busy"},  32'(busy),      32'd0);
        chk({v.name, "_fail"},  32'(fail),      32'(v.efail));
        chk({v.name, "_faddr"}, 32'(fail_addr), 32'(v.eaddr));
        chk({v.name, "_felem"}, 32'(fail_elem), 32'(v.eelem));
        chk({v.name, "_err"},   32'(err_count), 32'(v.eerr));
        chk({v.name, "_done4"}, 32'(done4),      32'd1);
        chk({v.name, "_fail4"}, 32'(fail4),      32'd1);
        chk({v.name, "_faddr4"}, 32'(fail_addr4), 32'd0);
        chk({v.name, "_felem4"}, 32'(fail_elem4), 32'd1);
        chk({v.name, "_err4"},  32'(err_count4), 32'd15);
        repeat (3) @(negedge clk);
        chk({v.name, "_hold_done"}, 32'(done),      32'd1);
        chk({v.name, "_hold_err"},  32'(err_count), 32'(v.eerr));
    endtask

    initial begin
        vecs[0] = '{name: "clean",    fault: 0, repulse: 1'b0, efail: 1'b0, eaddr: 4'd0, eelem: 3'd0, eerr: 8'd0};
        vecs[1] = '{name: "stuck_a5", fault: 1, repulse: 1'b1, efail: 1'b1, eaddr: 4'd5, eelem: 3'd1, eerr: 8'd3};
        vecs[2] = '{name: "rerun",    fault: 0, repulse: 1'b0, efail: 1'b0, eaddr: 4'd0, eelem: 3'd0, eerr: 8'd0};

        rst_n = 1'b0;
        start = 1'b0;
        fault_mode = 0;
        #12;
        check_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check_zero("idle");

        for (int i = 0; i < 3; i++) do_run(vecs[i]);

        // Asynchronous reset in the middle of a failing run.
        fault_mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (49) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_fail", 32'(fail), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk);
        check_zero("rst_held");
        rst_n = 1'b1;
        @(negedge clk);
        do_run(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/march_controller.md
Name: march_controller

Overview:
- Sequencer for the PMBIST datapath. Runs a March C- algorithm over a single-port synchronous memory and drives the address, write-data and read/write strobes.
- Presents the expected read data to the data comparator (its bist_data_in) in the cycle the memory returns data (its mem_data_in), and samples the comparator's 1-bit mismatch result.
- Accumulates pass/fail status, first-failure address/element and a saturating error count for the BIST status interface.

Parameters:
- dw, `DATA_WIDTH (8): memory/comparator data width.
- aw, `ADDR_WIDTH (4): memory address width; N = 2^aw words.
- cw, 8: error counter width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle run request.
- mem_addr  output  aw  memory address.
- mem_we  output  1  memory write strobe.
- mem_re  output  1  memory read strobe; memory returns read data one cycle later.
- mem_wdata  output  dw  write data.
- exp_data  output  dw  expected data, to comparator bist_data_in.
- cmp_fail  input  1  comparator mismatch (passfail_out), combinational from exp_data/mem rdata.
- busy  output  1  run in progress (RUN or FLUSH).
- done  output  1  run complete; held until next start.
- fail  output  1  at least one mismatch in current/last run.
- fail_addr  output  aw  address of first mismatch.
- fail_elem  output  3  March element (0-5) of first mismatch.
- err_count  output  cw  mismatch count, saturating at 2^cw-1.

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE. All outputs go to 0 and all counters and the check pipeline clear, including mid-run.
- States:
  - IDLE/DONE --start--> RUN.
  - RUN --last op of element 5 at last address--> FLUSH.
  - FLUSH --1 cycle--> DONE.
  - start in RUN or FLUSH is ignored.
- On start (from IDLE or DONE), in the same edge: fail, fail_addr, fail_elem and err_count clear to 0, done clears, and the element, op and address counters load element 0 / op 0 / address 0.
- March C- elements (background D0 = all 0s, D1 = all 1s):
  - E0 up (w0)
  - E1 up (r0,w1)
  - E2 up (r1,w0)
  - E3 down (r0,w1)
  - E4 down (r1,w0)
  - E5 up (r0)
- Operation sequencing:
  - One memory operation per RUN cycle; exactly one of mem_we/mem_re is high each RUN cycle, both low otherwise.
  - Multi-op elements perform all ops at one address before stepping to the next.
  - Up runs 0..N-1; down runs N-1..0.
  - On element change the address loads 0 (up) or N-1 (down) with no idle cycle.
  - RUN lasts exactly 10N cycles.
- Read check pipeline:
  - A read issued in cycle t sets chk_valid, chk_addr and chk_exp, and drives exp_data = chk_exp in cycle t+1.
  - cmp_fail is sampled at the end of cycle t+1 only when chk_valid = 1; it is ignored otherwise.
  - exp_data holds its last value when there is no check.
  - FLUSH exists solely to check E5's final read.
- On a sampled mismatch:
  - err_count increments, saturating; it never wraps.
  - If fail was 0: fail sets, and fail_addr/fail_elem capture chk_addr and the element of the read. Later mismatches do not overwrite them.
- A read check and a new memory operation coexist in the same cycle; this is not a conflict.
- busy: high in RUN and FLUSH.
- done: registered high on the FLUSH→DONE transition and held through DONE.
- Timing: with start sampled at edge E0, the first write (E0, address 0) is driven after E0, and done rises after edge E(10N+1).
- No loss of status: fail/err_count remain valid in DONE until the next start.

Test Plan:
- Fault-free memory model, aw=4 (N=16), start pulse → 160 RUN cycles, done high after edge 161, busy low in DONE, fail=0, err_count=0.
- Address/strobe trace, N=16 → E0 addresses 0..15 with mem_we=1, mem_wdata=0x00; E3 sequence re@15,we@15 (0xFF),re@14,… down to 0; E5 16 reads only; exp_data 0x00/0xFF matches element background one cycle after each mem_re.
- Address 5 bit0 stuck-at-1 → fail=1, fail_addr=5, fail_elem=1, err_count=3 (E1, E3, E5 reads of 0x00 fail; E2/E4 pass).
- Memory always returns inverted data, cw=4 → 80 mismatches counted, err_count saturates at 15, fail_addr=0, fail_elem=1.
- start re-pulsed at cycle 40 of a run → ignored, trace unchanged. Second start in DONE after the failing run → status clears, the new run completes with fresh results.
- rst_n asserted at RUN cycle 50 → all outputs 0 immediately (asynchronous), state IDLE. After release, start runs a complete 160-cycle sequence from E0 address 0.
